// File: rtl/ps2_key_fifo.sv
// PS/2 key front end: folds E0/F0 prefix bytes into key events and queues them in a FWFT FIFO.
// Latency: a code byte strobed at edge N is visible on key_valid/key_data/key_count after edge N.
// Backpressure: none upstream; pushes into a full FIFO are dropped and flagged in sticky overflow.

module key_fifo #(
  parameter int W      = 10,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_vld,
  input  logic [W-1:0]      wr_dat,
  input  logic              rd_rdy,
  output logic              rd_vld,
  output logic [W-1:0]      rd_dat,
  output logic [ADDR_W:0]   count,
  output logic              drop
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              empty;
  logic              full;
  logic              do_wr;
  logic              do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop on the same edge frees the slot, so a full FIFO still accepts that push.
  assign do_rd = rd_rdy && !empty;
  assign do_wr = wr_vld && (!full || do_rd);
  assign drop  = wr_vld && full && !do_rd;

  assign rd_vld = !empty;
  assign rd_dat = empty ? '0 : mem[rptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (do_rd) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; its contents are only observed through valid pointers.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wptr] <= wr_dat;
    end
  end

endmodule

module ps2_key_fifo #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int DROP_BREAK = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_key_pressed,
  input  logic [7:0]        ps2_out,
  input  logic              key_read,
  input  logic              ovf_clear,
  output logic              key_valid,
  output logic [31:0]       key_data,
  output logic [ADDR_W:0]   key_count,
  output logic              overflow
);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } pfx_state_t;

  pfx_state_t state_q;
  pfx_state_t state_d;
  key_evt_t   evt_dat;
  logic       evt_vld;
  key_evt_t   head_dat;
  logic       fifo_drop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    evt_dat = '0;
    evt_vld = 1'b0;
    if (ps2_key_pressed) begin
      unique case (ps2_out)
        8'hE0: begin
          if (state_q == IDLE)     state_d = EXT;
          else if (state_q == BRK) state_d = EXT_BRK;
        end
        8'hF0: begin
          if (state_q == IDLE)     state_d = BRK;
          else if (state_q == EXT) state_d = EXT_BRK;
        end
        default: begin
          evt_dat.ext  = (state_q == EXT) || (state_q == EXT_BRK);
          evt_dat.brk  = (state_q == BRK) || (state_q == EXT_BRK);
          evt_dat.code = ps2_out;
          // A suppressed release still consumes its prefix.
          evt_vld      = !((DROP_BREAK != 0) && evt_dat.brk);
          state_d      = IDLE;
        end
      endcase
    end
  end

  key_fifo #(
    .W      ($bits(key_evt_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_vld (evt_vld),
    .wr_dat (evt_dat),
    .rd_rdy (key_read),
    .rd_vld (key_valid),
    .rd_dat (head_dat),
    .count  (key_count),
    .drop   (fifo_drop)
  );

  assign key_data = {22'b0, head_dat};

  // A new overflow outranks a clear arriving on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed and random bench for ps2_key_fifo, default build and DROP_BREAK=1 build side by side.
module tb_ps2_key_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              ps2_key_pressed = 1'b0;
  logic [7:0]        ps2_out = 8'h00;
  logic              key_read = 1'b0;
  logic              ovf_clear = 1'b0;

  logic              kv0, kv1;
  logic [31:0]       kd0, kd1;
  logic [ADDR_W:0]   kc0, kc1;
  logic              ov0, ov1;

  int errors = 0;
  int checks = 0;

  logic [9:0] mq [2][$];
  bit         mext [2];
  bit         mbrk [2];
  bit         movf [2];

  always #5 clock = ~clock;

  ps2_key_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_BREAK(0)) dut0 (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .key_read(key_read), .ovf_clear(ovf_clear), .key_valid(kv0), .key_data(kd0),
    .key_count(kc0), .overflow(ov0));

  ps2_key_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_BREAK(1)) dut1 (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .key_read(key_read), .ovf_clear(ovf_clear), .key_valid(kv1), .key_data(kd1),
    .key_count(kc1), .overflow(ov1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: prefix flags plus a bounded queue of events.
  task automatic model_edge(input int k, input bit drop_brk);
    logic [9:0] evt;
    bit         pop;
    bit         push;
    if (!reset) begin
      mq[k].delete();
      mext[k] = 0;
      mbrk[k] = 0;
      movf[k] = 0;
      return;
    end
    pop  = key_read && (mq[k].size() > 0);
    push = 0;
    evt  = '0;
    if (ps2_key_pressed) begin
      if (ps2_out == 8'hE0) mext[k] = 1;
      else if (ps2_out == 8'hF0) mbrk[k] = 1;
      else begin
        evt  = {mext[k], mbrk[k], ps2_out};
        push = !(drop_brk && mbrk[k]);
        mext[k] = 0;
        mbrk[k] = 0;
      end
    end
    if (ovf_clear) movf[k] = 0;
    if (pop) void'(mq[k].pop_front());
    if (push) begin
      if (mq[k].size() == DEPTH) movf[k] = 1;
      else mq[k].push_back(evt);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] exp_d;
      exp_d = (mq[k].size() > 0) ? {22'b0, mq[k][0]} : 32'h0;
      chk($sformatf("valid%0d", k), {31'b0, (k == 0) ? kv0 : kv1}, {31'b0, mq[k].size() > 0});
      chk($sformatf("data%0d", k), (k == 0) ? kd0 : kd1, exp_d);
      chk($sformatf("count%0d", k), {28'b0, (k == 0) ? kc0 : kc1}, 32'(mq[k].size()));
      chk($sformatf("ovf%0d", k), {31'b0, (k == 0) ? ov0 : ov1}, {31'b0, movf[k]});
    end
  endtask

  task automatic step(input logic s, input logic [7:0] b, input logic r, input logic c);
    ps2_key_pressed = s;
    ps2_out         = b;
    key_read        = r;
    ovf_clear       = c;
    @(posedge clock);
    model_edge(0, 1'b0);
    model_edge(1, 1'b1);
    #1;
    ps2_key_pressed = 1'b0;
    key_read        = 1'b0;
    ovf_clear       = 1'b0;
    compare_all();
  endtask

  initial begin
    logic [7:0] pfx_seq [7];
    int         pfx_cnt [7];
    pfx_seq = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    pfx_cnt = '{0, 1, 1, 2, 2, 2, 3};

    // Reset held for two cycles, then a single make code.
    reset = 1'b0;
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("rst_valid", {31'b0, kv0}, 32'h0);
    chk("rst_data", kd0, 32'h0);
    reset = 1'b1;
    step(1, 8'h1C, 0, 0);
    chk("first_data", kd0, 32'h0000001C);
    chk("first_count", {28'b0, kc0}, 32'd1);
    step(0, 8'h00, 1, 0);

    // Prefix folding.
    for (int i = 0; i < 7; i++) begin
      step(1, pfx_seq[i], 0, 0);
      chk("pfx_count", {28'b0, kc0}, 32'(pfx_cnt[i]));
    end
    chk("pfx_pop0", kd0, 32'h11C);
    step(0, 8'h00, 1, 0);
    chk("pfx_pop1", kd0, 32'h275);
    step(0, 8'h00, 1, 0);
    chk("pfx_pop2", kd0, 32'h375);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // Fill past capacity, clear, then push+pop at full.
    for (int i = 1; i <= 9; i++) step(1, 8'(i), 0, 0);
    chk("fill_count", {28'b0, kc0}, 32'd8);
    chk("fill_ovf", {31'b0, ov0}, 32'd1);
    step(0, 8'h00, 0, 1);
    chk("ovf_clr", {31'b0, ov0}, 32'd0);
    step(1, 8'h2A, 1, 0);
    chk("full_pp_count", {28'b0, kc0}, 32'd8);
    chk("full_pp_ovf", {31'b0, ov0}, 32'd0);
    for (int i = 2; i <= 8; i++) begin
      chk("full_pp_pop", kd0, 32'(i));
      step(0, 8'h00, 1, 0);
    end
    chk("full_pp_tail", kd0, 32'h2A);
    step(0, 8'h00, 1, 0);

    // Overflow set wins over a simultaneous clear.
    for (int i = 0; i < 9; i++) step(1, 8'h40 + 8'(i), 0, 0);
    step(1, 8'h50, 0, 1);
    chk("set_wins", {31'b0, ov0}, 32'd1);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 1);

    // Pointer wrap, then pop on empty.
    for (int i = 0; i < 20; i++) begin
      step(1, 8'h20 + 8'(i), 0, 0);
      chk("wrap_data", kd0, 32'h20 + 32'(i));
      step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 1, 0);
    chk("empty_pop_count", {28'b0, kc0}, 32'd0);
    chk("empty_pop_data", kd0, 32'd0);

    // Empty with push and pop together.
    step(1, 8'h33, 1, 0);
    chk("empty_pp_count", {28'b0, kc0}, 32'd1);
    step(0, 8'h00, 1, 0);

    // Break suppression in the DROP_BREAK build.
    step(1, 8'hF0, 0, 0);
    step(1, 8'h1C, 0, 0);
    step(1, 8'h1C, 0, 0);
    chk("drop_count", {28'b0, kc1}, 32'd1);
    chk("drop_data", kd1, 32'h01C);
    chk("keep_count", {28'b0, kc0}, 32'd2);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // Reset between prefix and code discards the prefix.
    step(1, 8'hF0, 0, 0);
    reset = 1'b0;
    step(1, 8'h77, 0, 0);
    reset = 1'b1;
    step(1, 8'h1C, 0, 0);
    chk("rst_mid_data", kd0, 32'h01C);
    step(0, 8'h00, 1, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic       s, r, c;
      logic [7:0] b;
      int         sel;
      s   = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 9);
      b   = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      r   = ($urandom_range(0, 99) < 45);
      c   = ($urandom_range(0, 99) < 5);
      reset = ($urandom_range(0, 99) != 0);
      step(s, b, r, c);
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
